icache_responder: RTL and testbench

Direct-mapped, one-word-per-block instruction cache: the responder on the instruction half of the datapath/cache handshake. It answers fetch requests (imemREN, imemaddr) with ihit and imemload. On a miss it becomes the initiator toward the memory controller (iREN, iaddr, iwait, iload) and refills one frame. It sits between the pipelined datapath's fetch stage and the memory controller.

---
 rtl/cpu_types_pkg.sv | 18 +
 rtl/icache_responder_if.sv | 36 +++
 rtl/icache_frames.sv | 49 ++++
 rtl/icache_responder.sv | 130 +++++++++++++
 tb/tb_icache_responder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath/cache types for the instruction cache slice.
// Optional build macro: ICACHE_STATS_EN (hit/miss counters on icache_responder).
package cpu_types_pkg;

  // Machine word
  typedef logic [31:0] word_t;

  // Default number of instruction cache frames
  localparam int ICACHE_SETS = 16;

  // Fetch address split for the default ICACHE_SETS=16 geometry
  typedef struct packed {
    logic [25:0] tag;
    logic [3:0]  idx;
    logic [1:0]  bytoff;
  } icachef_t;

endpackage

// File: rtl/icache_responder_if.sv
// icache_responder_if: fetch handshake (datapath side) and refill handshake
// (memory-controller side) of the instruction cache, bundled in one interface.
//
// Handshake rules:
//   fetch : imemREN/imemaddr are held by the datapath; ihit=1 means imemload
//           is valid for imemaddr in this same cycle (combinational lookup).
//   refill: iREN/iaddr are held by the cache for the whole refill; the word on
//           iload is accepted in the first cycle where iREN=1 and iwait=0.
// state_dbg exposes the cache FSM state (0 = IDLE, 1 = FILL).
interface icache_responder_if;
  import cpu_types_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  halt;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;
  logic  state_dbg;

  // Cache view
  modport slave (
    input  imemREN, imemaddr, halt, iwait, iload,
    output ihit, imemload, iREN, iaddr, state_dbg
  );

  // Datapath + memory controller view
  modport master (
    output imemREN, imemaddr, halt, iwait, iload,
    input  ihit, imemload, iREN, iaddr, state_dbg
  );

endinterface

// File: rtl/icache_frames.sv
// icache_frames: SETS x (valid, tag, data) storage for the direct-mapped
// instruction cache. One write port, one combinational read port.
// Reset (synchronous, active-high nRST) clears every frame.
module icache_frames
  import cpu_types_pkg::*;
#(
  parameter int SETS  = ICACHE_SETS,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic             CLK,
  input  logic             nRST,
  // write port
  input  logic             we,
  input  logic [IDX_W-1:0] widx,
  input  logic [TAG_W-1:0] wtag,
  input  word_t            wdata,
  // read port
  input  logic [IDX_W-1:0] ridx,
  output logic             rvalid,
  output logic [TAG_W-1:0] rtag,
  output word_t            rdata
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_q  [SETS];
  word_t            data_q [SETS];

  // Frame update: reset clears all frames, otherwise one refill write
  always_ff @(posedge CLK) begin
    if (nRST) begin
      valid_q <= '0;
      tag_q   <= '{default: '0};
      data_q  <= '{default: '0};
    end else if (we) begin
      valid_q[widx] <= 1'b1;
      tag_q[widx]   <= wtag;
      data_q[widx]  <= wdata;
    end
  end

  // Combinational read of the addressed frame
  always_comb begin
    rvalid = valid_q[ridx];
    rtag   = tag_q[ridx];
    rdata  = data_q[ridx];
  end

endmodule

// File: rtl/icache_responder.sv
// icache_responder: direct-mapped, one-word-per-block instruction cache.
// Serves fetches with a zero-latency combinational lookup; on a miss it
// refills one frame from the memory controller. Refills always complete.
// Optional build macro: ICACHE_STATS_EN adds hit_count / miss_count outputs.
module icache_responder
  import cpu_types_pkg::*;
#(
  parameter int SETS = ICACHE_SETS
) (
  input  logic CLK,
  input  logic nRST,
  icache_responder_if.slave bus
`ifdef ICACHE_STATS_EN
  ,
  output word_t hit_count,
  output word_t miss_count
`endif
);

  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FILL = 1'b1;

  logic [0:0]       state_q, state_d;
  word_t            miss_addr_q, miss_addr_d;

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [1:0]       unused_bytoff;

  logic             r_valid;
  logic [TAG_W-1:0] r_tag;
  word_t            r_data;
  logic             lookup_hit;
  logic             fill_we;

  assign req_tag       = bus.imemaddr[31:IDX_W+2];
  assign req_idx       = bus.imemaddr[IDX_W+1:2];
  assign unused_bytoff = bus.imemaddr[1:0];

  // The refill write targets the latched miss address, not the live fetch
  // address, so a redirect during FILL cannot corrupt the frame.
  assign fill_we = (state_q == FILL) & ~bus.iwait;

  icache_frames #(
    .SETS (SETS)
  ) u_frames (
    .CLK    (CLK),
    .nRST   (nRST),
    .we     (fill_we),
    .widx   (miss_addr_q[IDX_W+1:2]),
    .wtag   (miss_addr_q[31:IDX_W+2]),
    .wdata  (bus.iload),
    .ridx   (req_idx),
    .rvalid (r_valid),
    .rtag   (r_tag),
    .rdata  (r_data)
  );

  assign lookup_hit = r_valid & (r_tag == req_tag);

  // Fetch response and refill request outputs
  always_comb begin
    bus.ihit      = (state_q == IDLE) & bus.imemREN & lookup_hit & ~nRST;
    bus.imemload  = r_data;
    bus.iREN      = (state_q == FILL);
    bus.iaddr     = miss_addr_q;
    bus.state_dbg = state_q;
  end

  // Next state: start a refill on an unhalted miss, leave FILL when data arrives
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    case (state_q)
      IDLE: begin
        if (bus.imemREN & ~lookup_hit & ~bus.halt) begin
          state_d     = FILL;
          miss_addr_d = {bus.imemaddr[31:2], 2'b00};
        end
      end
      FILL: begin
        if (~bus.iwait) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and latched miss address
  always_ff @(posedge CLK) begin
    if (nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
    end
  end

`ifdef ICACHE_STATS_EN
  word_t hit_q, hit_d;
  word_t miss_q, miss_d;

  // Saturating event counters
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (bus.ihit && (hit_q != 32'hFFFF_FFFF)) hit_d = hit_q + 32'd1;
    if ((state_q == IDLE) && (state_d == FILL) && (miss_q != 32'hFFFF_FFFF))
      miss_d = miss_q + 32'd1;
  end

  // Counter registers, cleared on reset
  always_ff @(posedge CLK) begin
    if (nRST) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: directed + random bench for icache_responder.
// The reference is a word-addressed picture of the cache: which word address
// each of the 16 frames holds, plus whether a refill is outstanding.
module tb_icache_responder;
  import cpu_types_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  icache_responder_if bus ();

`ifdef ICACHE_STATS_EN
  word_t hit_count, miss_count;
`endif

  icache_responder dut (
    .CLK  (clk),
    .nRST (nrst),
    .bus  (bus.slave)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // ---------------- reference model ----------------
  logic  m_vld  [16];
  word_t m_addr [16];
  word_t m_data [16];
  logic  m_fill;
  word_t m_fill_addr;
  word_t m_hits, m_miss;

  int errors = 0;
  int checks = 0;

  function automatic word_t mem_val(input word_t a);
    if (a == 32'h0000_0040) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic int frame_of(input word_t a);
    return int'((a >> 2) % 16);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_vld[i]  = 1'b0;
      m_addr[i] = '0;
      m_data[i] = '0;
    end
    m_fill      = 1'b0;
    m_fill_addr = '0;
    m_hits      = '0;
    m_miss      = '0;
  endtask

  // ---------------- driver + scoreboard: one clock cycle ----------------
  task automatic step(input logic ren, input word_t addr, input logic hlt,
                      input logic wt, input logic rst);
    word_t waddr;
    word_t load_v;
    logic  resident;
    logic  exp_hit;
    int    f;
    @(posedge clk);
    #1;
    waddr  = {addr[31:2], 2'b00};
    load_v = (m_fill && !wt) ? mem_val(m_fill_addr) : word_t'($urandom);
    bus.imemREN  = ren;
    bus.imemaddr = addr;
    bus.halt     = hlt;
    bus.iwait    = wt;
    bus.iload    = load_v;
    nrst         = rst;
    @(negedge clk);
    f        = frame_of(waddr);
    resident = m_vld[f] && (m_addr[f] == waddr);
    exp_hit  = !rst && !m_fill && ren && resident;
    chk("ihit", {31'd0, bus.ihit}, {31'd0, exp_hit});
    if (exp_hit) chk("imemload", bus.imemload, m_data[f]);
    chk("iREN", {31'd0, bus.iREN}, {31'd0, m_fill});
    chk("state", {31'd0, bus.state_dbg}, {31'd0, m_fill});
    if (m_fill) chk("iaddr", bus.iaddr, m_fill_addr);
`ifdef ICACHE_STATS_EN
    chk("hit_count", hit_count, m_hits);
    chk("miss_count", miss_count, m_miss);
`endif
    // advance the model to the next rising edge
    if (rst) begin
      model_reset();
    end else if (m_fill) begin
      if (!wt) begin
        f = frame_of(m_fill_addr);
        m_vld[f]  = 1'b1;
        m_addr[f] = m_fill_addr;
        m_data[f] = load_v;
        m_fill    = 1'b0;
      end
    end else if (exp_hit) begin
      if (m_hits != 32'hFFFF_FFFF) m_hits = m_hits + 1;
    end else if (ren && !hlt) begin
      m_fill      = 1'b1;
      m_fill_addr = waddr;
      if (m_miss != 32'hFFFF_FFFF) m_miss = m_miss + 1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    word_t a;
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.halt     = 1'b0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;
    model_reset();

    // reset
    step(0, 32'h0, 0, 1, 1);
    step(0, 32'h0, 0, 1, 1);
    step(0, 32'h0, 0, 1, 0);
    chk("rst_ihit", {31'd0, bus.ihit}, 32'd0);
    chk("rst_iren", {31'd0, bus.iREN}, 32'd0);
    chk("rst_iaddr", bus.iaddr, 32'd0);
    chk("rst_imemload", bus.imemload, 32'd0);

    // first miss on 0x40: three busy cycles, then data
    step(1, 32'h40, 0, 1, 0);
    chk("miss40_ihit", {31'd0, bus.ihit}, 32'd0);
    step(1, 32'h40, 0, 1, 0);
    chk("miss40_iren", {31'd0, bus.iREN}, 32'd1);
    chk("miss40_iaddr", bus.iaddr, 32'h40);
    step(1, 32'h40, 0, 1, 0);
    step(1, 32'h40, 0, 1, 0);
    step(1, 32'h40, 0, 0, 0);
    step(1, 32'h40, 0, 1, 0);
    chk("fill40_ihit", {31'd0, bus.ihit}, 32'd1);
    chk("fill40_data", bus.imemload, 32'h2008_0005);

    // repeat request: zero-latency hit, no refill
    step(1, 32'h40, 0, 1, 0);
    chk("rehit40_ihit", {31'd0, bus.ihit}, 32'd1);
    chk("rehit40_iren", {31'd0, bus.iREN}, 32'd0);

    // conflict: 0x440 shares frame 0 with 0x40
    step(1, 32'h440, 0, 1, 0);
    chk("conf_ihit", {31'd0, bus.ihit}, 32'd0);
    step(1, 32'h440, 0, 0, 0);
    chk("conf_iaddr", bus.iaddr, 32'h440);
    step(1, 32'h440, 0, 1, 0);
    chk("conf_hit440", {31'd0, bus.ihit}, 32'd1);
    step(1, 32'h40, 0, 1, 0);
    chk("conf_evict40", {31'd0, bus.ihit}, 32'd0);
    step(0, 32'h40, 0, 0, 0);

    // redirect mid-fill: 0x80 completes, then 0x100 misses
    step(1, 32'h80, 0, 1, 0);
    step(1, 32'h100, 0, 1, 0);
    chk("redir_iaddr80", bus.iaddr, 32'h80);
    step(1, 32'h100, 0, 0, 0);
    step(1, 32'h100, 0, 1, 0);
    chk("redir_miss100", {31'd0, bus.ihit}, 32'd0);
    step(1, 32'h100, 0, 1, 0);
    chk("redir_iaddr100", bus.iaddr, 32'h100);
    step(1, 32'h100, 0, 0, 0);
    step(1, 32'h100, 0, 1, 0);
    chk("redir_hit100", {31'd0, bus.ihit}, 32'd1);

    // halt: a missing address never starts a refill, resident one still hits
    for (int i = 0; i < 6; i++) begin
      step(1, 32'h204, 1, 0, 0);
      chk("halt_iren", {31'd0, bus.iREN}, 32'd0);
    end
    step(1, 32'h100, 1, 1, 0);
    chk("halt_hit", {31'd0, bus.ihit}, 32'd1);

    // reset during FILL with data arriving in the same cycle
    step(1, 32'h40, 0, 1, 0);
    step(1, 32'h40, 0, 0, 0);
    step(1, 32'h40, 0, 1, 0);
    chk("pre_rst_hit40", {31'd0, bus.ihit}, 32'd1);
    step(1, 32'h204, 0, 1, 0);
    step(1, 32'h204, 0, 0, 1);
    step(1, 32'h40, 0, 1, 0);
    chk("post_rst_iren", {31'd0, bus.iREN}, 32'd0);
    chk("post_rst_miss40", {31'd0, bus.ihit}, 32'd0);
`ifdef ICACHE_STATS_EN
    chk("post_rst_hits", hit_count, 32'd0);
    chk("post_rst_miss", miss_count, 32'd0);
`endif
    step(0, 32'h0, 0, 0, 0);
    step(1, 32'h204, 0, 1, 0);
    chk("post_rst_miss204", {31'd0, bus.ihit}, 32'd0);
    step(0, 32'h0, 0, 0, 0);

    // random traffic over a small address pool to mix hits, conflicts, redirects
    for (int n = 0; n < 600; n++) begin
      a = (word_t'($urandom_range(0, 3)) << 6) | (word_t'($urandom_range(0, 3)) << 2)
          | word_t'($urandom_range(0, 3));
      step(($urandom_range(0, 9) < 8), a, ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 99) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
